// File: rtl/conv3x3_stream_engine.sv
// ============================================================================
// Module      : conv3x3_stream_engine
// Description : Streaming 3x3 convolution over a raster pixel stream. Two
//               line buffers plus a 3x3 shift window feed a signed MAC
//               stage, an arithmetic right shift and an output register.
//               Latency is 3 enabled cycles. The whole pipeline stalls
//               together on downstream backpressure.
// Ports       : clk, rst (async, active-high)
//               cfg_img_width, cfg_shift, flat_weights - sampled on s_sof
//               s_valid/s_ready/s_sof/s_data          - pixel input stream
//               m_valid/m_ready/m_data/m_eol          - result output stream
// Options     : CONV_OUT_SATURATE_EN - clamp result to [0, 2^OUT_WIDTH-1]
//               instead of truncating to OUT_WIDTH bits.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv3x3_stream_engine #(
  parameter int DATA_WIDTH    = 8,
  parameter int MAX_IMG_WIDTH = 64,
  parameter int ACC_WIDTH     = 32,
  parameter int OUT_WIDTH     = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [$clog2(MAX_IMG_WIDTH+1)-1:0]   cfg_img_width,
  input  logic [4:0]                           cfg_shift,
  input  logic [9*DATA_WIDTH-1:0]              flat_weights,
  input  logic                                 s_valid,
  output logic                                 s_ready,
  input  logic                                 s_sof,
  input  logic [DATA_WIDTH-1:0]                s_data,
  output logic                                 m_valid,
  input  logic                                 m_ready,
  output logic [OUT_WIDTH-1:0]                 m_data,
  output logic                                 m_eol
);

  localparam int CW = $clog2(MAX_IMG_WIDTH + 1);
  localparam int AW = (MAX_IMG_WIDTH > 1) ? $clog2(MAX_IMG_WIDTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FILL = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;

  logic [1:0]                    state_q, state_d;
  logic [CW-1:0]                 col_q, col_d;
  logic [1:0]                    row_q, row_d;   // saturates at 2: only row>=2 matters
  logic [CW-1:0]                 width_q;
  logic [4:0]                    shift_q;
  logic [9*DATA_WIDTH-1:0]       weights_q;

  logic [DATA_WIDTH-1:0]         lb0_q [MAX_IMG_WIDTH];  // previous line
  logic [DATA_WIDTH-1:0]         lb1_q [MAX_IMG_WIDTH];  // line before that
  logic [DATA_WIDTH-1:0]         win_q [3][3];           // [row][col], col 2 newest

  logic                          v1_q, eol1_q, v2_q, eol2_q;
  logic signed [ACC_WIDTH-1:0]   sum2_q;
  logic [4:0]                    shift2_q;
  logic                          m_valid_q, m_eol_q;
  logic [OUT_WIDTH-1:0]          m_data_q;

  logic                          w_en, w_accept, w_sof, w_active, w_last_col, w_fire;
  logic [CW-1:0]                 w_width, w_pos_col;
  logic [1:0]                    w_pos_row;
  logic [AW-1:0]                 w_addr;
  logic [DATA_WIDTH-1:0]         w_lb0_rd, w_lb1_rd;
  logic signed [ACC_WIDTH-1:0]   w_px, w_wt, w_sum, w_res;
  logic [OUT_WIDTH-1:0]          w_out;

  assign w_en     = !m_valid_q || m_ready;
  assign s_ready  = w_en;
  assign w_accept = s_valid && w_en;
  assign w_sof    = w_accept && s_sof;
  // Pixels outside a frame (IDLE, no sof) are consumed but ignored.
  assign w_active = w_sof || (w_accept && (state_q != S_IDLE));

  // A sof pixel sits at (0,0) and uses the freshly presented width.
  assign w_width    = s_sof ? cfg_img_width : width_q;
  assign w_pos_col  = s_sof ? '0 : col_q;
  assign w_pos_row  = s_sof ? 2'd0 : row_q;
  assign w_last_col = (w_pos_col == (w_width - CW'(1)));
  assign w_addr     = w_pos_col[AW-1:0];
  assign w_lb0_rd   = lb0_q[w_addr];
  assign w_lb1_rd   = lb1_q[w_addr];

  // RUN implies width>=3, so stale line-buffer contents never reach a valid window.
  assign w_fire = w_active && !s_sof && (state_q == S_RUN) &&
                  (row_q == 2'd2) && (col_q >= CW'(2));

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    if (w_active) begin
      col_d = w_last_col ? '0 : (w_pos_col + CW'(1));
      row_d = (w_last_col && (w_pos_row != 2'd2)) ? (w_pos_row + 2'd1) : w_pos_row;
      if (w_sof) begin
        state_d = S_FILL;
      end else if ((state_q == S_FILL) && (row_q == 2'd2) && (col_q == '0) &&
                   (width_q >= CW'(3))) begin
        state_d = S_RUN;
      end
    end
  end

  // Signed MAC over the window; pixels zero-extended, weights sign-extended.
  always_comb begin
    w_sum = '0;
    w_px  = '0;
    w_wt  = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        w_px  = {{(ACC_WIDTH-DATA_WIDTH){1'b0}}, win_q[i][j]};
        w_wt  = {{(ACC_WIDTH-DATA_WIDTH){weights_q[(i*3+j)*DATA_WIDTH + DATA_WIDTH-1]}},
                 weights_q[(i*3+j)*DATA_WIDTH +: DATA_WIDTH]};
        w_sum = w_sum + (w_px * w_wt);
      end
    end
  end

  assign w_res = sum2_q >>> shift2_q;

`ifdef CONV_OUT_SATURATE_EN
  localparam logic signed [ACC_WIDTH-1:0] OUT_MAX = ACC_WIDTH'((64'd1 << OUT_WIDTH) - 64'd1);
  always_comb begin
    if (w_res < 0)            w_out = '0;
    else if (w_res > OUT_MAX) w_out = '1;
    else                      w_out = OUT_WIDTH'(w_res);
  end
`else
  assign w_out = OUT_WIDTH'(w_res);
`endif

  // Datapath storage without reset; validity is tracked by the reset flops.
  always_ff @(posedge clk) begin
    if (w_active) begin
      lb0_q[w_addr] <= s_data;
      lb1_q[w_addr] <= w_lb0_rd;
      for (int r = 0; r < 3; r++) begin
        win_q[r][0] <= win_q[r][1];
        win_q[r][1] <= win_q[r][2];
      end
      win_q[0][2] <= w_lb1_rd;
      win_q[1][2] <= w_lb0_rd;
      win_q[2][2] <= s_data;
    end
    if (w_en) begin
      eol1_q   <= w_last_col;
      eol2_q   <= eol1_q;
      sum2_q   <= w_sum;
      // Shift travels with the data so a new frame's shift cannot hit old results.
      shift2_q <= shift_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      col_q     <= '0;
      row_q     <= '0;
      width_q   <= '0;
      shift_q   <= '0;
      weights_q <= '0;
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_eol_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      if (w_sof) begin
        width_q   <= cfg_img_width;
        shift_q   <= cfg_shift;
        weights_q <= flat_weights;
      end
      if (w_en) begin
        v1_q      <= w_fire;
        v2_q      <= v1_q;
        m_valid_q <= v2_q;
        if (v2_q) begin
          m_data_q <= w_out;
          m_eol_q  <= eol2_q;
        end
      end
    end
  end

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_eol   = m_eol_q;

endmodule

`default_nettype wire

// File: doc/conv3x3_stream_engine.md
CONV3X3_STREAM_ENGINE -- requirements
Module: conv3x3_stream_engine

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: unsigned pixel width and signed weight width.
REQ-002 SHALL have parameter MAX_IMG_WIDTH, default 64: maximum line length and line-buffer depth.
REQ-003 SHALL have parameter ACC_WIDTH, default 32: signed accumulator width.
REQ-004 SHALL have parameter OUT_WIDTH, default 8: output pixel width.
REQ-005 SHALL have port clk  input  1  single clock, rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous reset, active-high.
REQ-007 SHALL have port cfg_img_width  input  $clog2(MAX_IMG_WIDTH+1)  line length in pixels.
REQ-008 SHALL have port cfg_shift  input  5  arithmetic right shift applied to the sum.
REQ-009 SHALL have port flat_weights  input  9*DATA_WIDTH  k00 at bits [DATA_WIDTH-1:0], row-major through k22 at the MSBs.
REQ-010 SHALL have port s_valid  input  1  input pixel valid.
REQ-011 SHALL have port s_ready  output  1  input pixel accepted when s_valid and s_ready are both high.
REQ-012 SHALL have port s_sof  input  1  start of frame, qualified by the accept.
REQ-013 SHALL have port s_data  input  DATA_WIDTH  unsigned pixel.
REQ-014 SHALL have port m_valid  output  1  output pixel valid.
REQ-015 SHALL have port m_ready  input  1  downstream ready.
REQ-016 SHALL have port m_data  output  OUT_WIDTH  convolved pixel.
REQ-017 SHALL have port m_eol  output  1  last output pixel of an output row.

Function
REQ-018 SHALL stall the entire pipeline (line buffers, window, MAC stages, counters) together: enable = !m_valid || m_ready; s_ready = enable.
REQ-019 SHALL track the column and row of each accepted pixel; column wraps at cfg_img_width-1, with row incremented on wrap.
REQ-020 SHALL sample cfg_img_width, cfg_shift and flat_weights on an accepted s_sof pixel; changes to them mid-frame SHALL be ignored until the next s_sof.
REQ-021 SHALL implement the state machine IDLE -> FILL on accepted s_sof; FILL -> RUN on accepting the pixel at row 2, column 0; RUN -> FILL on accepted s_sof.
REQ-022 SHALL treat an s_sof-accepted pixel as position (0,0) in any state.
REQ-023 SHALL form each window from the two previous lines plus the current line; a window SHALL be produced only for an accepted pixel with row>=2 and col>=2, giving a (W-2)x(H-2) output.
REQ-024 SHALL compute sum = sum over i,j of kij*p(r-2+i, c-2+j), with pixels zero-extended, weights signed, and the sum in ACC_WIDTH two's complement; overflow wraps.
REQ-025 SHALL compute result = sum >>> cfg_shift (arithmetic shift).
REQ-026 SHALL present m_valid exactly 3 enabled cycles after the accept of a window-completing pixel (latency 3, no stalls).
REQ-027 SHALL assert m_eol with the output for col = cfg_img_width-1.
REQ-028 SHALL produce no outputs and stay in FILL when cfg_img_width < 3.
REQ-029 SHALL deliver outputs already in flight when a mid-frame s_sof arrives; no output of the old frame SHALL be dropped or duplicated.
REQ-030 SHALL hold m_data and m_eol stable while m_valid=1 and m_ready=0.
REQ-031 SHALL sustain one pixel per cycle in and out when m_ready is held high.

Reset
REQ-032 SHALL on rst set state IDLE, counters 0, m_valid 0, m_data 0, m_eol 0, and all pipeline valid bits 0; s_ready is therefore 1.
REQ-033 SHALL NOT reset line-buffer storage; FILL gating masks stale data.
REQ-034 SHALL on rst asserted mid-frame discard all in-flight results, and SHALL produce no output until a new s_sof.

Configuration
REQ-035 SHALL, with CONV_OUT_SATURATE_EN defined, clamp result to [0, 2^OUT_WIDTH-1]: negative -> 0, above max -> all ones.
REQ-036 SHALL, without CONV_OUT_SATURATE_EN, output m_data = result[OUT_WIDTH-1:0] (wrap).

Verification
REQ-037 SHALL cover identity: width 5, 5x5 ramp 0..24, k11=1, others 0, shift 0, m_ready=1 -> 9 outputs 6,7,8,11,12,13,16,17,18; m_eol on 8, 13, 18; each 3 cycles after its input.
REQ-038 SHALL cover box sum: width 4, all pixels 10, all weights 1, shift 3 -> each output 90>>>3=11; 4 outputs.
REQ-039 SHALL cover saturation: all pixels 255, k00=-1, others 0 -> with CONV_OUT_SATURATE_EN output 0, without it output 0x01; then all weights 1 with SAT -> 255.
REQ-040 SHALL cover backpressure: REQ-037 stimulus with m_ready toggled in a 1-in-3 pattern -> an identical output sequence, s_ready low exactly when m_valid=1 and m_ready=0, and m_data stable while stalled.
REQ-041 SHALL cover restart: s_sof reasserted at row 3 col 1 of a width-5 frame -> pending old outputs delivered, no new output until the new frame's (2,2).
REQ-042 SHALL cover reset mid-frame: rst pulsed at row 2 -> m_valid=0 next cycle, and no output until s_sof.
